// File: rtl/zero_frame_transmitter.sv
// Serial frame transmitter for a two-consecutive-zeros line detector.
// Each frame is a 00 start marker, then the payload MSB-first with a 1 stuffed
// after every payload 0, then a single stop bit of 1. The line idles at 1.
module zero_frame_transmitter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [2:0]       present_state
);

  // Counter must hold 0..WIDTH inclusive.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    MARK0 = 3'b001,
    MARK1 = 3'b010,
    DATA  = 3'b011,
    STUFF = 3'b100,
    STOP  = 3'b101
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sr_reg, sr_next, sr_shifted;
  logic [CW-1:0]    cnt_reg, cnt_next, cnt_inc;
  logic             cur_bit;

  // Left shift by one with a 0 entering the LSB.
  assign sr_shifted[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign sr_shifted[gi] = sr_reg[gi-1];
    end
  endgenerate

  assign cur_bit = sr_reg[WIDTH-1];
  assign cnt_inc = cnt_reg + CW'(1);

  // State, shift register and bit counter; reset abandons any frame in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; unused codes fall back to IDLE.
  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          sr_next    = data_in;
          cnt_next   = '0;
          state_next = MARK0;
        end
      end
      MARK0: state_next = MARK1;
      MARK1: state_next = DATA;
      DATA: begin
        sr_next  = sr_shifted;
        cnt_next = cnt_inc;
        if (!cur_bit) begin
          state_next = STUFF;
        end else if (cnt_inc == LAST_CNT) begin
          state_next = STOP;
        end else begin
          state_next = DATA;
        end
      end
      STUFF: begin
        if (cnt_reg == LAST_CNT) begin
          state_next = STOP;
        end else begin
          state_next = DATA;
        end
      end
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs: line level depends only on state and the shift register MSB.
  always_comb begin
    x    = 1'b1;
    busy = 1'b1;
    done = 1'b0;
    case (state_reg)
      IDLE:    busy = 1'b0;
      MARK0:   x = 1'b0;
      MARK1:   x = 1'b0;
      DATA:    x = cur_bit;
      STUFF:   x = 1'b1;
      STOP:    done = 1'b1;
      default: begin
        x    = 1'b1;
        busy = 1'b1;
        done = 1'b0;
      end
    endcase
  end

  assign present_state = state_reg;

endmodule

// File: doc/zero_frame_transmitter.md
Name: zero_frame_transmitter

Overview:
- Serial frame transmitter that drives the single-bit line `x` sampled by the two-consecutive-zeros detector.
- Loads a WIDTH-bit word and emits a frame start marker of two 0s, then the payload MSB-first, then one stop bit.
- A 1 is stuffed after every payload 0, so the only 00 pair on the line is the start marker; the receiver's detection pulse therefore marks frame start.
- The line idles at 1.

Parameters:
WIDTH, 8, payload bits per frame (legal range WIDTH >= 2).

Ports:
clock  input  1  rising-edge system clock
reset  input  1  asynchronous, active-low reset
load  input  1  request to start a frame; sampled on clock edge, honoured only when busy=0
data_in  input  WIDTH  payload word; captured on the edge that accepts load
x  output  1  serial line to detector; Moore output (function of state register and shift register MSB only)
busy  output  1  high in every state except IDLE
done  output  1  high for exactly the one STOP cycle of each frame
present_state  output  3  current FSM state encoding, for observation

Behaviour:
- State encoding: IDLE=000, MARK0=001, MARK1=010, DATA=011, STUFF=100, STOP=101.
- Codes 110 and 111 go to IDLE on the next edge.
- Registers: state, WIDTH-bit shift register `sr`, and bit counter `cnt` sized to hold 0..WIDTH.
- x per state: IDLE=1, MARK0=0, MARK1=0, DATA=sr[WIDTH-1], STUFF=1, STOP=1.
- busy=0 only in IDLE. done=1 only in STOP.
- Reset (reset==0, asynchronous, overrides everything):
  - state=IDLE, sr=0, cnt=0.
  - Outputs immediately x=1, busy=0, done=0, present_state=000.
  - Reset mid-frame abandons the frame; there is no resume.
- IDLE: if load=1, then sr<=data_in, cnt<=0, next state MARK0. Otherwise stay. Latency: x goes 0 in the first cycle after the accepting edge.
- MARK0 -> MARK1 unconditionally.
- MARK1 -> DATA unconditionally.
- DATA (bit emitted is b=sr[WIDTH-1]): on each edge, sr<=sr<<1 (LSB filled with 0) and cnt<=cnt+1. Then:
  - b=0 -> STUFF.
  - b=1 and cnt+1==WIDTH -> STOP.
  - b=1 otherwise -> stay in DATA.
- STUFF -> STOP if cnt==WIDTH, else DATA. sr and cnt hold.
- STOP -> IDLE. A load in STOP is ignored, so back-to-back frames have at least one IDLE cycle at x=1 between them.
- load while busy: ignored. data_in changes while busy have no effect.
- Frame length (busy cycles) = 3 + WIDTH + (number of 0s in payload).
- Line property: outside the start marker, x never shows two consecutive 0s. The marker followed by a payload MSB of 0 gives 000, which is still a single detection.

Test Plan:
- Reset held low for 3 time units, then released, load=0 for 5 cycles -> x=1, busy=0, done=0, present_state=000 throughout.
- load=1 with data_in=8'hA5 for one edge -> the 15 busy cycles must show:
  - x sequence 0,0,1,0,1,1,0,1,0,1,1,0,1,1,1;
  - done=1 only on the 15th cycle;
  - IDLE after, with x=1.
  - A detector on x asserts y exactly once, at the marker.
- data_in=8'h00 -> 19 busy cycles, x=0,0 then (0,1) repeated 8 times then 1; done on cycle 19.
- data_in=8'hFF -> 11 busy cycles, x=0,0,1,1,1,1,1,1,1,1,1.
- load held high continuously with data_in=8'hFF -> each frame is 11 busy cycles followed by exactly 1 IDLE cycle (x=1, busy=0), then the next MARK0; data_in changes mid-frame do not alter the emitted bits.
- Reset asserted in the middle of the DATA phase of an 8'hA5 frame -> x=1, busy=0, done=0, present_state=000 immediately (before the next edge). After release, load with 8'h81 emits a clean frame 0,0,1,0,1,0,1,0,1,0,1,0,1,0,1,1,1 (17 busy cycles).
